// File: rtl/spectro_column_writer.sv
// spectro_column_writer
//
// Turns a stream of FFT magnitude beats (bin 0 first, mag_last on the final
// bin) into pixel writes for a banked spectrogram display RAM.  Each complete
// frame fills one display column.  The column ring holds NO_FFTS columns
// spread across NO_BANKS banks of COLS_PER_BANK columns each.
//
// Handshake: a beat transfers on any rising clk edge where mag_valid and
// mag_ready are both high.  mag_ready is low only during the single COMMIT
// cycle that follows a complete frame, and while reset is applied.  The
// producer may hold mag_valid high across a low-ready cycle; the beat is not
// taken until ready returns.
//
// Ports
//   clk, reset        : sole clock; asynchronous active-high reset
//   mag_valid/ready   : magnitude beat handshake
//   mag_data          : unsigned bin magnitude
//   mag_last          : final bin of a frame
//   scale_mode        : 0 = linear (shifted, saturated), 1 = log2 bit length
//   shift             : linear-mode right shift
//   freeze            : consume frames without writing or advancing the ring
//   disp_wr_en        : RAM write strobe, one cycle after the beat is taken
//   disp_bank_wr      : target bank
//   disp_wr_address   : column base + bin within the bank
//   disp_data_wr      : quantised pixel
//   OLDEST_FFT_IDX    : oldest valid column once the ring has filled
//   column_done       : one-cycle pulse two cycles after the last beat
//   frame_error       : one-cycle pulse for a frame whose mag_last is misplaced
//   dbg_state         : current FSM state (IDLE=0, WRITE=1, COMMIT=2)
module spectro_column_writer #(
  parameter int FFT_SIZE       = 256,
  parameter int NO_FFTS        = 50,
  parameter int NO_BANKS       = 2,
  parameter int RAM_ADDR_WIDTH = 12,
  parameter int MAG_WIDTH      = 16,
  parameter int DATA_WIDTH     = 4,
  localparam int BINS          = FFT_SIZE / 2,
  localparam int COLS_PER_BANK = (2 ** RAM_ADDR_WIDTH) / BINS,
  localparam int BANK_WIDTH    = (NO_BANKS > 1) ? $clog2(NO_BANKS) : 1,
  localparam int IDX_WIDTH     = $clog2(NO_FFTS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      mag_valid,
  output logic                      mag_ready,
  input  logic [MAG_WIDTH-1:0]      mag_data,
  input  logic                      mag_last,
  input  logic                      scale_mode,
  input  logic [3:0]                shift,
  input  logic                      freeze,
  output logic                      disp_wr_en,
  output logic [BANK_WIDTH-1:0]     disp_bank_wr,
  output logic [RAM_ADDR_WIDTH-1:0] disp_wr_address,
  output logic [DATA_WIDTH-1:0]     disp_data_wr,
  output logic [IDX_WIDTH-1:0]      OLDEST_FFT_IDX,
  output logic                      column_done,
  output logic                      frame_error,
  output logic [1:0]                dbg_state
);

  // Bin counter needs to reach BINS so overlong frames saturate there.
  localparam int BIN_W   = $clog2(BINS + 1);
  localparam int CIB_W   = (COLS_PER_BANK > 1) ? $clog2(COLS_PER_BANK) : 1;
  localparam int PIX_MAX = (2 ** DATA_WIDTH) - 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WRITE  = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;

  generate
    if (NO_BANKS * COLS_PER_BANK < NO_FFTS) begin : g_size_check
      $error("display RAM too small for NO_FFTS columns");
    end
  endgenerate

  logic [1:0]                state_q, state_d;
  logic [BIN_W-1:0]          bin_q, bin_d;
  logic                      ready_q;
  logic                      frz_q, frz_d, mode_q, mode_d;
  logic [3:0]                shift_q, shift_d;
  logic [IDX_WIDTH-1:0]      wcol_q, wcol_d, oldest_q, oldest_d;
  logic [BANK_WIDTH-1:0]     wbank_q, wbank_d;
  logic [CIB_W-1:0]          wcib_q, wcib_d;
  logic                      fill_q, fill_d;
  logic                      wr_en_q, wr_en_d, done_q, err_q, err_d;
  logic [BANK_WIDTH-1:0]     bank_q, bank_d;
  logic [RAM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]     data_q, data_d, pix;

  logic                      accept, first, commit;
  logic                      frz_eff, mode_eff;
  logic [3:0]                shift_eff;
  logic [BIN_W-1:0]          beat_bin;
  logic [31:0]               lin32;
  int                        bit_len;

  assign accept = mag_valid && ready_q;
  // The first beat of a frame arrives in IDLE; its controls apply directly,
  // later beats use the copies captured on that beat.
  assign first     = (state_q == S_IDLE);
  assign frz_eff   = first ? freeze     : frz_q;
  assign mode_eff  = first ? scale_mode : mode_q;
  assign shift_eff = first ? shift      : shift_q;
  assign beat_bin  = first ? '0 : bin_q;
  assign commit    = (state_q == S_COMMIT) && !frz_q;

  // floor(log2(x)) + 1 is the position of the highest set bit plus one.
  always_comb begin
    bit_len = 0;
    for (int i = 0; i < MAG_WIDTH; i++) begin
      if (mag_data[i]) bit_len = i + 1;
    end
  end

  assign lin32 = 32'(mag_data) >> shift_eff;

  always_comb begin
    pix = '0;
    if (mode_eff) pix = (bit_len > PIX_MAX) ? DATA_WIDTH'(PIX_MAX) : DATA_WIDTH'(bit_len);
    else          pix = (lin32 > 32'(PIX_MAX)) ? DATA_WIDTH'(PIX_MAX) : DATA_WIDTH'(lin32);
  end

  // Frame sequencing
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    err_d   = 1'b0;
    frz_d   = frz_q;
    mode_d  = mode_q;
    shift_d = shift_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          frz_d   = freeze;
          mode_d  = scale_mode;
          shift_d = shift;
          if (mag_last) begin
            err_d = 1'b1;
          end else begin
            state_d = S_WRITE;
            bin_d   = BIN_W'(1);
          end
        end
      end
      S_WRITE: begin
        if (accept) begin
          if (mag_last) begin
            bin_d = '0;
            if (bin_q == BIN_W'(BINS - 1)) begin
              state_d = S_COMMIT;
            end else begin
              state_d = S_IDLE;
              err_d   = 1'b1;
            end
          end else if (bin_q != BIN_W'(BINS)) begin
            bin_d = bin_q + BIN_W'(1);
          end
        end
      end
      S_COMMIT: state_d = S_IDLE;
      default: begin
        state_d = S_IDLE;
        bin_d   = '0;
      end
    endcase
  end

  // Column ring: the bank / column-in-bank pair is stepped alongside wcol
  // so no divider is needed to locate the column.
  always_comb begin
    wcol_d   = wcol_q;
    wbank_d  = wbank_q;
    wcib_d   = wcib_q;
    fill_d   = fill_q;
    oldest_d = oldest_q;
    if (commit) begin
      if (wcol_q == IDX_WIDTH'(NO_FFTS - 1)) begin
        wcol_d  = '0;
        wbank_d = '0;
        wcib_d  = '0;
        fill_d  = 1'b1;
      end else begin
        wcol_d = wcol_q + IDX_WIDTH'(1);
        if (wcib_q == CIB_W'(COLS_PER_BANK - 1)) begin
          wcib_d  = '0;
          wbank_d = wbank_q + BANK_WIDTH'(1);
        end else begin
          wcib_d = wcib_q + CIB_W'(1);
        end
      end
      oldest_d = fill_d ? wcol_d : '0;
    end
  end

  // Pixel write for the beat being accepted this cycle
  always_comb begin
    wr_en_d = accept && !frz_eff && (beat_bin < BIN_W'(BINS));
    bank_d  = '0;
    addr_d  = '0;
    data_d  = '0;
    if (wr_en_d) begin
      bank_d = wbank_q;
      addr_d = RAM_ADDR_WIDTH'(int'(wcib_q) * BINS + int'(beat_bin));
      data_d = pix;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      bin_q    <= '0;
      ready_q  <= 1'b0;
      frz_q    <= 1'b0;
      mode_q   <= 1'b0;
      shift_q  <= '0;
      wcol_q   <= '0;
      wbank_q  <= '0;
      wcib_q   <= '0;
      fill_q   <= 1'b0;
      oldest_q <= '0;
      wr_en_q  <= 1'b0;
      bank_q   <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      bin_q    <= bin_d;
      ready_q  <= (state_d != S_COMMIT);
      frz_q    <= frz_d;
      mode_q   <= mode_d;
      shift_q  <= shift_d;
      wcol_q   <= wcol_d;
      wbank_q  <= wbank_d;
      wcib_q   <= wcib_d;
      fill_q   <= fill_d;
      oldest_q <= oldest_d;
      wr_en_q  <= wr_en_d;
      bank_q   <= bank_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      done_q   <= commit;
      err_q    <= err_d;
    end
  end

  assign mag_ready       = ready_q;
  assign disp_wr_en      = wr_en_q;
  assign disp_bank_wr    = bank_q;
  assign disp_wr_address = addr_q;
  assign disp_data_wr    = data_q;
  assign OLDEST_FFT_IDX  = oldest_q;
  assign column_done     = done_q;
  assign frame_error     = err_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_spectro_column_writer.sv
// Bench for spectro_column_writer with default parameters.
// Driver tasks issue frames and push expected writes / pulses (tagged with
// the cycle they must appear in) into queues; a negedge monitor pops and
// compares whenever the DUT presents a write, column_done or frame_error.
module tb_spectro_column_writer;

  localparam int BINS    = 128;
  localparam int NO_FFTS = 50;
  localparam int CPB     = 32;
  localparam int BW      = 1;
  localparam int RAW     = 12;
  localparam int DW      = 4;
  localparam int IW      = 6;
  localparam int PIXMAX  = 15;
  localparam int WW      = 32 + BW + RAW + DW;
  localparam int DNW     = 32 + IW;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           mag_valid = 1'b0;
  logic           mag_ready;
  logic [15:0]    mag_data = '0;
  logic           mag_last = 1'b0;
  logic           scale_mode = 1'b0;
  logic [3:0]     shift = '0;
  logic           freeze = 1'b0;
  logic           disp_wr_en;
  logic [BW-1:0]  disp_bank_wr;
  logic [RAW-1:0] disp_wr_address;
  logic [DW-1:0]  disp_data_wr;
  logic [IW-1:0]  OLDEST_FFT_IDX;
  logic           column_done;
  logic           frame_error;
  logic [1:0]     dbg_state;

  spectro_column_writer dut (
    .clk(clk), .reset(reset),
    .mag_valid(mag_valid), .mag_ready(mag_ready), .mag_data(mag_data),
    .mag_last(mag_last), .scale_mode(scale_mode), .shift(shift), .freeze(freeze),
    .disp_wr_en(disp_wr_en), .disp_bank_wr(disp_bank_wr),
    .disp_wr_address(disp_wr_address), .disp_data_wr(disp_data_wr),
    .OLDEST_FFT_IDX(OLDEST_FFT_IDX), .column_done(column_done),
    .frame_error(frame_error), .dbg_state(dbg_state)
  );

  // ---------------- clock / cycle count ----------------
  initial forever #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [WW-1:0]  exp_q[$];
  logic [DNW-1:0] done_q[$];
  logic [31:0]    err_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  int m_wcol = 0;
  int m_commits = 0;
  logic [15:0] fdata [0:BINS+7];

  function automatic int q_lin(input int m, input int sh);
    int v;
    v = m / (2 ** sh);
    return (v > PIXMAX) ? PIXMAX : v;
  endfunction

  function automatic int q_log(input int m);
    int n;
    n = 0;
    while (m > 0) begin
      m = m / 2;
      n++;
    end
    return (n > PIXMAX) ? PIXMAX : n;
  endfunction

  // ---------------- monitor ----------------
  logic [WW-1:0]  mon_w;
  logic [DNW-1:0] mon_d;
  always @(negedge clk) begin
    if (!reset) begin
      if (disp_wr_en) begin
        if (exp_q.size() == 0) chk("unexpected_write", {disp_bank_wr, disp_wr_address}, 0);
        else begin
          mon_w = exp_q.pop_front();
          chk("write{cyc,bank,addr,data}", {cyc, disp_bank_wr, disp_wr_address, disp_data_wr}, mon_w);
        end
      end
      if (column_done) begin
        if (done_q.size() == 0) chk("unexpected_column_done", 1, 0);
        else begin
          mon_d = done_q.pop_front();
          chk("column_done{cyc,oldest}", {cyc, OLDEST_FFT_IDX}, mon_d);
        end
      end
      if (frame_error) begin
        if (err_q.size() == 0) chk("unexpected_frame_error", 1, 0);
        else chk("frame_error_cycle", cyc, err_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    @(negedge clk);
    mag_valid = 1'b0;
    mag_last  = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic drive_beat(input logic [15:0] d, input bit last, input bit frz,
                            input bit mode, input logic [3:0] sh,
                            output int acc, output bit ok);
    ok = 1'b0;
    acc = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      mag_valid  = 1'b1;
      mag_data   = d;
      mag_last   = last;
      freeze     = frz;
      scale_mode = mode;
      shift      = sh;
      if (mag_ready) begin
        acc = cyc + 1;
        ok  = 1'b1;
        break;
      end
    end
    if (!ok) begin
      mag_valid = 1'b0;
      chk("mag_ready_timeout", 0, 1);
    end
  endtask

  // n beats of fdata; frame-level controls come from the first beat, and
  // with tog set all controls are flipped for the second half of the frame.
  task automatic send_frame(input int n, input bit has_last, input bit frz,
                            input bit mode, input int sh, input bit tog);
    int acc;
    bit ok;
    bit f_i, m_i;
    int s_i, v;
    for (int i = 0; i < n; i++) begin
      f_i = frz; m_i = mode; s_i = sh;
      if (tog && i >= n / 2) begin
        f_i = ~frz; m_i = ~mode; s_i = (sh + 5) % 16;
      end
      drive_beat(fdata[i], has_last && (i == n - 1), f_i, m_i, 4'(s_i), acc, ok);
      if (!ok) return;
      if (!frz && i < BINS) begin
        v = mode ? q_log(int'(fdata[i])) : q_lin(int'(fdata[i]), sh);
        exp_q.push_back({32'(acc), BW'(m_wcol / CPB), RAW'((m_wcol % CPB) * BINS + i), DW'(v)});
      end
      if (has_last && i == n - 1) begin
        if (i == BINS - 1) begin
          if (!frz) begin
            m_wcol = (m_wcol + 1) % NO_FFTS;
            m_commits++;
            done_q.push_back({32'(acc + 1), IW'((m_commits >= NO_FFTS) ? m_wcol : 0)});
          end
        end else begin
          err_q.push_back(32'(acc));
        end
      end
    end
    idle(1);
  endtask

  task automatic fill_random();
    for (int i = 0; i < BINS + 8; i++)
      fdata[i] = 16'($urandom_range(0, 65535) >> $urandom_range(0, 15));
  endtask

  task automatic good_frame();
    fill_random();
    send_frame(BINS, 1'b1, 1'b0, 1'($urandom_range(0, 1)), $urandom_range(0, 15), 1'($urandom_range(0, 1)));
  endtask

  task automatic random_extra();
    int kind;
    kind = $urandom_range(0, 5);
    fill_random();
    if (kind == 0) send_frame(BINS, 1'b1, 1'b1, 1'($urandom_range(0, 1)), $urandom_range(0, 15), 1'($urandom_range(0, 1)));
    else if (kind == 1) send_frame($urandom_range(1, BINS - 1), 1'b1, 1'b0, 1'($urandom_range(0, 1)), $urandom_range(0, 15), 1'b0);
    else if (kind == 2) send_frame($urandom_range(BINS + 1, BINS + 4), 1'b1, 1'b0, 1'($urandom_range(0, 1)), $urandom_range(0, 15), 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_mag_ready"}, mag_ready, 0);
    chk({tag, "_disp_wr_en"}, disp_wr_en, 0);
    chk({tag, "_disp_bank_wr"}, disp_bank_wr, 0);
    chk({tag, "_disp_wr_address"}, disp_wr_address, 0);
    chk({tag, "_disp_data_wr"}, disp_data_wr, 0);
    chk({tag, "_oldest"}, OLDEST_FFT_IDX, 0);
    chk({tag, "_column_done"}, column_done, 0);
    chk({tag, "_frame_error"}, frame_error, 0);
    chk({tag, "_state"}, dbg_state, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    #12;
    check_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    idle(2);

    // linear, shift 4: bin 5 -> 0xF, bin 6 saturates to 0xF
    fill_random();
    fdata[5] = 16'h00F0;
    fdata[6] = 16'h0100;
    send_frame(BINS, 1'b1, 1'b0, 1'b0, 4, 1'b0);
    idle(2);
    chk("oldest_after_first_commit", OLDEST_FFT_IDX, 0);

    // log mode: 0 -> 0, 0x100 -> 9, 0xFFFF -> 15
    fill_random();
    fdata[0] = 16'h0000;
    fdata[1] = 16'h0100;
    fdata[2] = 16'hFFFF;
    send_frame(BINS, 1'b1, 1'b0, 1'b1, 0, 1'b0);

    // mag_last on bin 60, then mag_last on the very first beat
    fill_random();
    send_frame(61, 1'b1, 1'b0, 1'b0, 2, 1'b0);
    chk("oldest_after_malformed", OLDEST_FFT_IDX, 0);
    fill_random();
    send_frame(1, 1'b1, 1'b0, 1'b1, 0, 1'b0);
    chk("state_after_first_beat_last", dbg_state, 0);
    chk("ready_after_first_beat_last", mag_ready, 1);

    // frozen frame with controls toggled mid-frame, then a normal frame
    fill_random();
    send_frame(BINS, 1'b1, 1'b1, 1'b0, 3, 1'b1);
    good_frame();

    while (m_commits < 50) begin
      random_extra();
      good_frame();
    end
    idle(2);
    chk("oldest_after_50_commits", OLDEST_FFT_IDX, 0);
    good_frame();
    idle(2);
    chk("oldest_after_51_commits", OLDEST_FFT_IDX, 1);
    while (m_commits < 100) begin
      random_extra();
      good_frame();
    end
    idle(2);
    chk("oldest_after_100_commits", OLDEST_FFT_IDX, 0);

    // reset after bin 40 of a frame with a prior column committed
    good_frame();
    fill_random();
    send_frame(41, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    idle(1);
    chk("pending_writes_before_reset", exp_q.size(), 0);
    #2 reset = 1'b1;
    #1 check_all_zero("midreset");
    m_wcol = 0;
    m_commits = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    good_frame();
    idle(2);
    chk("oldest_after_reset_commit", OLDEST_FFT_IDX, 0);
    for (int k = 0; k < 3; k++) begin
      random_extra();
      good_frame();
    end
    idle(4);

    chk("write_queue_drained", exp_q.size(), 0);
    chk("done_queue_drained", done_q.size(), 0);
    chk("error_queue_drained", err_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spectro_column_writer.md
SPECTRO_COLUMN_WRITER -- requirements
Module: spectro_column_writer

Interface
REQ-001 Parameters (name, default, meaning), each SHALL be honoured as listed:
- FFT_SIZE, 256, FFT length; bins per column BINS = FFT_SIZE/2.
- NO_FFTS, 50, columns in the display ring.
- NO_BANKS, 2, display RAM banks.
- RAM_ADDR_WIDTH, 12, per-bank address width.
- MAG_WIDTH, 16, input magnitude width.
- DATA_WIDTH, 4, RAM pixel width.
REQ-002 Derived values SHALL be:
- COLS_PER_BANK = 2^RAM_ADDR_WIDTH / BINS.
- BANK_WIDTH = max(1, clog2(NO_BANKS)).
- IDX_WIDTH = clog2(NO_FFTS).
- The block SHALL require NO_BANKS*COLS_PER_BANK >= NO_FFTS; elaboration SHALL fail otherwise.
REQ-003 Ports (name, direction, width, meaning):
- clk  in  1  sole clock.
- reset  in  1  asynchronous, active-high reset.
- mag_valid  in  1  magnitude beat valid.
- mag_ready  out  1  block accepts beat.
- mag_data  in  MAG_WIDTH  unsigned bin magnitude, bin 0 first.
- mag_last  in  1  final bin of frame.
- scale_mode  in  1  0 = linear, 1 = log2.
- shift  in  4  linear right-shift amount.
- freeze  in  1  consume frames without writing.
- disp_wr_en  out  1  RAM write strobe.
- disp_bank_wr  out  BANK_WIDTH  target bank.
- disp_wr_address  out  RAM_ADDR_WIDTH  target address.
- disp_data_wr  out  DATA_WIDTH  pixel value.
- OLDEST_FFT_IDX  out  IDX_WIDTH  oldest valid column.
- column_done  out  1  one-cycle commit pulse.
- frame_error  out  1  one-cycle malformed-frame pulse.

Function
REQ-004 A beat SHALL be accepted when mag_valid && mag_ready.
REQ-005 FSM states SHALL be IDLE, WRITE and COMMIT; mag_ready SHALL be high in IDLE and WRITE and low in COMMIT.
REQ-006 IDLE transitions:
- Accept with mag_last=0 -> WRITE, bin counter = 1.
- Accept with mag_last=1 -> stay in IDLE, pulse frame_error.
REQ-007 WRITE transitions:
- Accept with mag_last=1 and bin == BINS-1 -> COMMIT.
- Accept with mag_last=1 and bin != BINS-1 -> IDLE, pulse frame_error, no commit.
- Otherwise bin increments, saturating at BINS.
REQ-008 COMMIT SHALL last exactly one cycle and then return to IDLE.
REQ-009 freeze, scale_mode and shift SHALL be sampled on the first accepted beat of a frame and held for the whole frame.
REQ-010 Each accepted beat with bin < BINS and freeze clear SHALL produce, one cycle after acceptance:
- disp_wr_en = 1.
- disp_bank_wr = wcol / COLS_PER_BANK.
- disp_wr_address = (wcol mod COLS_PER_BANK)*BINS + bin.
- disp_data_wr = the quantised value (REQ-011/REQ-012).
Here wcol is the current write column.
REQ-011 Linear mode: disp_data_wr = min(mag_data >> shift, 2^DATA_WIDTH-1).
REQ-012 Log mode: disp_data_wr = 0 if mag_data == 0, else min(floor(log2(mag_data))+1, 2^DATA_WIDTH-1).
REQ-013 Beats with bin >= BINS, and all beats of a frozen frame, SHALL produce disp_wr_en = 0.
REQ-014 Beats SHALL still be accepted at full rate when freeze is set; a frozen frame SHALL NOT advance wcol.
REQ-015 On leaving COMMIT with freeze clear:
- wcol SHALL advance modulo NO_FFTS.
- column_done SHALL pulse in the following cycle.
REQ-016 OLDEST_FFT_IDX SHALL be 0 until NO_FFTS columns have been committed; from then on it SHALL equal the new wcol, updated in the same cycle as column_done.
REQ-017 A malformed frame SHALL leave its partial writes in RAM and SHALL NOT advance wcol or OLDEST_FFT_IDX.
REQ-018 Wrap-around: a commit at wcol = NO_FFTS-1 SHALL set wcol = 0.
REQ-019 Latency from acceptance of the last bin to column_done SHALL be 2 cycles.

Reset
REQ-020 While reset is high (asynchronous), the block SHALL hold:
- state = IDLE, wcol = 0, bin counter = 0, fill flag cleared.
- OLDEST_FFT_IDX = 0.
- disp_wr_en, column_done and frame_error = 0.
- disp_bank_wr, disp_wr_address and disp_data_wr = 0.
- mag_ready = 0.
REQ-021 Reset asserted mid-frame SHALL abandon the frame; the next accepted beat after release SHALL be treated as bin 0.

Verification
REQ-022 Defaults, linear mode, shift = 4, 128-beat frame with bin 5 = 0x00F0 and bin 6 = 0x0100 -> bank 0, addr 5 data 0xF; addr 6 data 0xF (saturated); column_done 2 cycles after last beat; OLDEST_FFT_IDX = 0.
REQ-023 Log mode, bin 0 = 0x0000, bin 1 = 0x0100, bin 2 = 0xFFFF -> data 0, 9, 15.
REQ-024 Commit 33 frames -> frame 33 (wcol = 32) writes bank 1, addr 0..127; after 50 commits OLDEST_FFT_IDX = 0, after 51 commits = 1, after 100 commits = 0.
REQ-025 mag_last on bin 60 -> frame_error pulse, no column_done, wcol unchanged; mag_last on the first beat -> frame_error, FSM stays in IDLE.
REQ-026 freeze high at frame start, toggled mid-frame -> 128 beats accepted, no disp_wr_en, wcol unchanged; next frame with freeze low is written.
REQ-027 Reset pulse after bin 40 -> all outputs 0 immediately; following 128-beat frame written from addr 0 of column 0.
